life_step_sched: RTL and testbench
==================================

LIFE_STEP_SCHED -- requirements
Module: life_step_sched

Interface
REQ-001 Parameter FRAMES_PER_GEN, default 30, SHALL set the base number of vertical-blank intervals per generation in run mode; legal range 1..255.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of gen_count.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock (25 MHz pixel clock); all logic is on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the reset, which is synchronous and active-high.
REQ-005 Port vblank, input, 1 bit, SHALL be high during vertical blanking, synchronous to clk.
REQ-006 Port run, input, 1 bit, SHALL select run mode when 1 and pause mode when 0 (level).
REQ-007 Port step_btn, input, 1 bit, SHALL be a debounced single-step request, synchronous to clk (level).
REQ-008 Port clr_btn, input, 1 bit, SHALL be a debounced grid-clear request, synchronous to clk (level).
REQ-009 Port rate_sel, input, 2 bits, SHALL be the speed select; divider = max(1, FRAMES_PER_GEN >> rate_sel).
REQ-010 Port gen_done, input, 1 bit, SHALL be the engine's single-cycle completion pulse for a step or a clear.
REQ-011 Port gen_req, output, 1 bit, SHALL request one Game-of-Life generation from the engine.
REQ-012 Port clr_req, output, 1 bit, SHALL request the engine to zero the 32x32 grid.
REQ-013 Port gen_count, output, CNT_W bits, SHALL hold the number of generations completed since the last clear or reset.
REQ-014 Port busy, output, 1 bit, SHALL be high while in REQ or CLR.
REQ-015 Port overrun, output, 1 bit, SHALL be a sticky flag set when the engine is still busy as vblank falls.

Function
REQ-016 Detection: vblank, step_btn and clr_btn SHALL each be registered once; a rise is defined as cur & ~prev.
REQ-017 Pending bits: a step_btn rise SHALL set step_pend only while run=0 and SHALL be ignored while run=1; a clr_btn rise SHALL set clr_pend in any mode. Each pending bit is one deep and is set regardless of state.
REQ-018 Frame counter (8 bits): on each vblank rise with run=1 it SHALL increment, wrapping to 0 after reaching divider-1; while run=0 it SHALL be held at 0.
REQ-019 Run trigger: a run trigger SHALL occur on a vblank rise where run=1 and the frame counter equals divider-1 (evaluated before the increment); with divider=1, every vblank rise is a trigger.
REQ-020 State machine: the states SHALL be IDLE, REQ and CLR.
REQ-021 Transitions from IDLE, evaluated only on a vblank rise:
- if clr_pend, go to CLR and clear clr_pend;
- else if step_pend or a run trigger, go to REQ and clear step_pend;
- otherwise stay in IDLE.
REQ-022 In REQ, gen_req SHALL be high; when gen_done=1, the next state is IDLE and gen_count increments, wrapping modulo 2^CNT_W.
REQ-023 In CLR, clr_req SHALL be high; when gen_done=1, the next state is IDLE and gen_count is set to 0.
REQ-024 gen_req and clr_req SHALL be registered, SHALL never be high together, and SHALL fall in the cycle after gen_done is sampled.
REQ-025 A run trigger occurring while in REQ or CLR SHALL be dropped, with no queuing.
REQ-026 Overrun: if vblank falls while the state is REQ or CLR, overrun SHALL be set and held until reset.
REQ-027 gen_done received in IDLE SHALL be ignored.
REQ-028 A rate_sel or run change SHALL take effect at the next vblank rise and SHALL NOT abort a request in flight.

Reset
REQ-029 While rst=1 at a clk edge, the block SHALL enter IDLE with gen_req=0, clr_req=0, busy=0, overrun=0, gen_count=0, frame counter=0 and both pending bits cleared.
REQ-030 The edge-detect registers SHALL load their current inputs during reset, so a level held high through reset does not produce a rise afterward.
REQ-031 Reset asserted mid-request SHALL drop gen_req/clr_req at the next edge; a later gen_done SHALL be ignored.

Verification
REQ-032 run=1, FRAMES_PER_GEN=4, rate_sel=0, engine acks 3 cycles after req -> gen_req rises on every 4th vblank rise; gen_count = 5 after 20 frames.
REQ-033 run=0, one step_btn pulse -> exactly one gen_req at the next vblank rise; gen_count goes 0 -> 1; further vblanks produce no request.
REQ-034 clr_btn and step_btn pulsed in the same frame while paused -> CLR is served first (gen_count = 0), then REQ at the following vblank rise (gen_count = 1).
REQ-035 gen_done withheld past the vblank fall -> overrun = 1 and remains 1 after gen_done; a run trigger during busy produces no extra request.
REQ-036 rst pulsed while gen_req=1, gen_count=7 -> next edge gen_req=0, gen_count=0; a following stray gen_done leaves the state in IDLE.
REQ-037 rate_sel=3 with FRAMES_PER_GEN=4 -> divider = 1; a request is issued on every vblank rise.

Source files
------------

// File: rtl/life_step_sched.sv
// Game-of-Life generation scheduler: paces step/clear requests to the grid engine
// off vertical blanking, with run/pause, single-step, clear and speed select.
module life_step_sched #(
    parameter int FRAMES_PER_GEN = 30,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vblank,
    input  logic             run,
    input  logic             step_btn,
    input  logic             clr_btn,
    input  logic [1:0]       rate_sel,
    input  logic             gen_done,
    output logic             gen_req,
    output logic             clr_req,
    output logic [CNT_W-1:0] gen_count,
    output logic             busy,
    output logic             overrun
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_CLR} state_t;

    localparam logic [7:0] FPG = 8'(FRAMES_PER_GEN);

    state_t           state_q, state_d;
    logic             vblank_q, step_q, clr_q;
    logic             step_pend_q, step_pend_d;
    logic             clr_pend_q, clr_pend_d;
    logic [7:0]       fcnt_q, fcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovr_q, ovr_d;
    logic             gen_req_q, clr_req_q;
    logic [7:0]       div_raw, div_m1;
    logic             vb_rise, vb_fall, step_rise, clr_rise, frame_last, trig;

    assign vb_rise   = vblank & ~vblank_q;
    assign vb_fall   = ~vblank & vblank_q;
    assign step_rise = step_btn & ~step_q;
    assign clr_rise  = clr_btn & ~clr_q;

    assign div_raw = FPG >> rate_sel;
    assign div_m1  = (div_raw == 8'd0) ? 8'd0 : div_raw - 8'd1;
    // >= rather than == so a speed-up while the counter is past the new
    // terminal value wraps on the next rise instead of counting through 255.
    assign frame_last = (fcnt_q >= div_m1);
    assign trig       = vb_rise & run & frame_last;

    always_comb begin
        state_d     = state_q;
        step_pend_d = step_pend_q;
        clr_pend_d  = clr_pend_q;
        fcnt_d      = fcnt_q;
        cnt_d       = cnt_q;
        ovr_d       = ovr_q;

        if (!run)
            fcnt_d = 8'd0;
        else if (vb_rise)
            fcnt_d = frame_last ? 8'd0 : fcnt_q + 8'd1;

        case (state_q)
            S_IDLE: begin
                if (vb_rise) begin
                    if (clr_pend_q) begin
                        state_d    = S_CLR;
                        clr_pend_d = 1'b0;
                    end else if (step_pend_q || trig) begin
                        state_d     = S_REQ;
                        step_pend_d = 1'b0;
                    end
                end
            end
            S_REQ: begin
                if (gen_done) begin
                    state_d = S_IDLE;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_CLR: begin
                if (gen_done) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A fresh press arriving in the same cycle a pending bit is consumed is kept.
        if (step_rise && !run) step_pend_d = 1'b1;
        if (clr_rise)          clr_pend_d  = 1'b1;

        if (vb_fall && state_q != S_IDLE) ovr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        vblank_q <= vblank;
        step_q   <= step_btn;
        clr_q    <= clr_btn;
        if (rst) begin
            state_q     <= S_IDLE;
            step_pend_q <= 1'b0;
            clr_pend_q  <= 1'b0;
            fcnt_q      <= 8'd0;
            cnt_q       <= '0;
            ovr_q       <= 1'b0;
            gen_req_q   <= 1'b0;
            clr_req_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_pend_q <= step_pend_d;
            clr_pend_q  <= clr_pend_d;
            fcnt_q      <= fcnt_d;
            cnt_q       <= cnt_d;
            ovr_q       <= ovr_d;
            gen_req_q   <= (state_d == S_REQ);
            clr_req_q   <= (state_d == S_CLR);
        end
    end

    assign gen_req   = gen_req_q;
    assign clr_req   = clr_req_q;
    assign busy      = gen_req_q | clr_req_q;
    assign gen_count = cnt_q;
    assign overrun   = ovr_q;
endmodule

// File: tb/tb_life_step_sched.sv
// Directed bench for life_step_sched with FRAMES_PER_GEN=4.
module tb_life_step_sched;
    logic        clk = 1'b0;
    logic        rst, vblank, run, step_btn, clr_btn, gen_done;
    logic [1:0]  rate_sel;
    logic        gen_req, clr_req, busy, overrun;
    logic [15:0] gen_count;

    logic        eng_en = 1'b0, eng_done = 1'b0, tbl_done = 1'b0;
    int          ecnt = 0, req_rises = 0, both_hi = 0;
    logic        gr_prev = 1'b0;
    int          n_tests = 0, n_fail = 0;

    assign gen_done = eng_en ? eng_done : tbl_done;

    life_step_sched #(.FRAMES_PER_GEN(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .vblank(vblank), .run(run), .step_btn(step_btn),
        .clr_btn(clr_btn), .rate_sel(rate_sel), .gen_done(gen_done),
        .gen_req(gen_req), .clr_req(clr_req), .gen_count(gen_count),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Engine model: acks 3 cycles after a request is seen.
    always @(negedge clk) begin
        if (!eng_en) begin
            eng_done = 1'b0;
            ecnt     = 0;
        end else if (eng_done) begin
            eng_done = 1'b0;
            ecnt     = 0;
        end else if (gen_req || clr_req) begin
            ecnt++;
            if (ecnt == 3) eng_done = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (gen_req && !gr_prev) req_rises++;
        if (gen_req && clr_req) both_hi++;
        gr_prev = gen_req;
    end

    typedef struct {
        logic        vb, rn, st, cl, dn;
        logic        greq, creq, bsy, ovr;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(input logic vb, rn, st, cl, dn,
                                input logic greq, creq, bsy, ovr, input logic [15:0] cnt);
        vec_t v;
        v.vb = vb; v.rn = rn; v.st = st; v.cl = cl; v.dn = dn;
        v.greq = greq; v.creq = creq; v.bsy = bsy; v.ovr = ovr; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {12'd0, gen_req, clr_req, busy, overrun, gen_count};
    endfunction

    task automatic frame(input int hi, input int lo);
        repeat (hi) begin @(negedge clk); vblank = 1'b1; end
        repeat (lo) begin @(negedge clk); vblank = 1'b0; end
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    int base;

    initial begin
        //            vb rn st cl dn   greq creq bsy ovr cnt
        tbl[0]  = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 0, 0,   0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 1, 0, 0,   0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 0, 0, 0, 0,   1, 0, 1, 0, 0);
        tbl[4]  = mk(1, 0, 0, 0, 0,   1, 0, 1, 0, 0);
        tbl[5]  = mk(1, 0, 0, 0, 1,   0, 0, 0, 0, 1);
        tbl[6]  = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 1);
        tbl[7]  = mk(1, 0, 0, 0, 0,   0, 0, 0, 0, 1);
        tbl[8]  = mk(0, 0, 0, 0, 1,   0, 0, 0, 0, 1);
        tbl[9]  = mk(0, 0, 1, 1, 0,   0, 0, 0, 0, 1);
        tbl[10] = mk(1, 0, 0, 0, 0,   0, 1, 1, 0, 1);
        tbl[11] = mk(1, 0, 0, 0, 1,   0, 0, 0, 0, 0);
        tbl[12] = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        tbl[13] = mk(1, 0, 0, 0, 0,   1, 0, 1, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0,   1, 0, 1, 1, 0);
        tbl[15] = mk(0, 0, 0, 0, 1,   0, 0, 0, 1, 1);
        tbl[16] = mk(0, 0, 0, 0, 0,   0, 0, 0, 1, 1);

        rst = 1'b1; vblank = 1'b0; run = 1'b0; step_btn = 1'b0; clr_btn = 1'b0;
        rate_sel = 2'd0;
        repeat (2) cyc();
        chk("reset_state", outs(), 32'd0);
        @(negedge clk); rst = 1'b0;

        // Paused: single step, stray done, clear-before-step, overrun.
        foreach (tbl[i]) begin
            @(negedge clk);
            vblank = tbl[i].vb; run = tbl[i].rn; step_btn = tbl[i].st;
            clr_btn = tbl[i].cl; tbl_done = tbl[i].dn;
            cyc();
            chk($sformatf("vec%0d", i), outs(),
                {12'd0, tbl[i].greq, tbl[i].creq, tbl[i].bsy, tbl[i].ovr, tbl[i].cnt});
        end

        // Run mode, divider 4, engine acks after 3 cycles.
        @(negedge clk); rst = 1'b1; tbl_done = 1'b0;
        cyc();
        chk("reset_clears_overrun", {31'd0, overrun}, 32'd0);
        @(negedge clk); rst = 1'b0; run = 1'b1; rate_sel = 2'd0; eng_en = 1'b1;
        base = req_rises;
        for (int f = 1; f <= 20; f++) begin
            frame(5, 15);
            chk($sformatf("run_f%0d", f), {gen_count, 16'(req_rises - base)},
                {16'(f / 4), 16'(f / 4)});
        end
        chk("run_overrun", {31'd0, overrun}, 32'd0);

        // rate_sel=3 -> divider 1: a request every vblank.
        @(negedge clk); rate_sel = 2'd3;
        for (int f = 6; f <= 7; f++) begin
            frame(5, 5);
            chk($sformatf("div1_f%0d", f), {16'd0, gen_count}, 32'(f));
        end

        // Reset in the middle of a request, then a stray done.
        @(negedge clk); eng_en = 1'b0; tbl_done = 1'b0; vblank = 1'b1;
        cyc();
        chk("midreq_pre", {30'd0, gen_req, busy} << 16 | gen_count, {14'd0, 2'b11, 16'd7});
        @(negedge clk); rst = 1'b1;
        cyc();
        chk("midreq_rst", outs(), 32'd0);
        @(negedge clk); rst = 1'b0; tbl_done = 1'b1;
        cyc();
        @(negedge clk); tbl_done = 1'b0;
        repeat (3) cyc();
        chk("stray_done_idle", outs(), 32'd0);

        // Overrun and a trigger dropped while busy.
        @(negedge clk); vblank = 1'b0;
        repeat (2) cyc();
        base = req_rises;
        @(negedge clk); vblank = 1'b1;
        repeat (2) cyc();
        @(negedge clk); vblank = 1'b0;
        repeat (2) cyc();
        @(negedge clk); vblank = 1'b1;
        repeat (2) cyc();
        chk("ovr_busy", {28'd0, gen_req, busy, overrun, 1'b0}, {28'd0, 4'b1110});
        @(negedge clk); tbl_done = 1'b1;
        cyc();
        @(negedge clk); tbl_done = 1'b0;
        repeat (3) cyc();
        chk("ovr_sticky", outs(), {12'd0, 4'b0001, 16'd1});
        @(negedge clk);
        chk("dropped_trig", 32'(req_rises - base), 32'd1);

        // Step press while running is ignored after switching to pause.
        @(negedge clk); vblank = 1'b0; step_btn = 1'b1;
        @(negedge clk); step_btn = 1'b0; run = 1'b0;
        repeat (2) cyc();
        @(negedge clk); vblank = 1'b1;
        repeat (3) cyc();
        chk("step_in_run_ignored", {31'd0, busy}, 32'd0);
        chk("req_clr_exclusive", 32'(both_hi), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
